// File: rtl/pc_unit_if.sv
// Control-unit <-> PC-unit bundle: requests from the control unit, PC and status back.
// The control side uses the master modport; the pc_unit itself takes the slave modport.
interface pc_unit_if #(
  parameter int unsigned LENGTH = 11
);
  logic              start;
  logic              enable;
  logic              jump;
  logic [LENGTH-1:0] jump_addr;
  logic              branch;
  logic [LENGTH-1:0] branch_offset;
  logic              halt;
  logic [LENGTH-1:0] pc;
  logic [LENGTH-1:0] pc_plus_step;
  logic              running;
  logic              halted;
  logic              wrapped;

  modport master (
    output start, enable, jump, jump_addr, branch, branch_offset, halt,
    input  pc, pc_plus_step, running, halted, wrapped
  );

  modport slave (
    input  start, enable, jump, jump_addr, branch, branch_offset, halt,
    output pc, pc_plus_step, running, halted, wrapped
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with step/jump/branch, stall and IDLE/RUN/HALTED control; 1-cycle latency.
// No backpressure: every request is either consumed or dropped on the edge it is sampled.
module pc_unit #(
  parameter int unsigned LENGTH   = 11,
  parameter int unsigned STEP     = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LENGTH-1:0] pc_q, pc_d;
  logic              wrap_d;
  logic              running_q, halted_q, wrapped_q;
  logic [LENGTH:0]   inc_sum;

  // Extra top bit of the increment is the overflow flag behind wrapped.
  assign inc_sum = {1'b0, pc_q} + (LENGTH+1)'(STEP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.enable) begin
          if (bus.jump) begin
            pc_d = bus.jump_addr;
          end else if (bus.branch) begin
            pc_d = pc_q + bus.branch_offset;
          end else begin
            pc_d   = inc_sum[LENGTH-1:0];
            wrap_d = inc_sum[LENGTH];
          end
        end
      end
      HALTED: begin
        if (bus.start) state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= LENGTH'(RESET_PC);
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= (state_d == RUN);
      halted_q  <= (state_d == HALTED);
      wrapped_q <= wrap_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus_step = inc_sum[LENGTH-1:0];
  assign bus.running      = running_q;
  assign bus.halted       = halted_q;
  assign bus.wrapped      = wrapped_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table against the STEP=1/RESET_PC=0 instance,
// plus hand-written sequences for STEP=2 wrap and RESET_PC=0x040 reset behaviour.
module tb_pc_unit;

  localparam int unsigned L = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.LENGTH(L)) b0 ();
  pc_unit_if #(.LENGTH(L)) b1 ();
  pc_unit_if #(.LENGTH(L)) b2 ();

  pc_unit #(.LENGTH(L), .STEP(1), .RESET_PC(0))     dut0 (.clk(clk), .rst(rst), .bus(b0));
  pc_unit #(.LENGTH(L), .STEP(2), .RESET_PC(0))     dut1 (.clk(clk), .rst(rst), .bus(b1));
  pc_unit #(.LENGTH(L), .STEP(1), .RESET_PC('h040)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    bit         rst;
    bit         start;
    bit         en;
    bit         jmp;
    bit [L-1:0] ja;
    bit         br;
    bit [L-1:0] bo;
    bit         hlt;
  } stim_t;

  typedef struct {
    stim_t      s;
    bit [L-1:0] pc;
    bit         run;
    bit         hlt;
    bit         wr;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vq[$];

  function automatic stim_t st(bit r, bit s, bit e, bit j, bit [L-1:0] ja, bit b, bit [L-1:0] bo, bit h);
    stim_t x;
    x.rst = r; x.start = s; x.en = e; x.jmp = j; x.ja = ja; x.br = b; x.bo = bo; x.hlt = h;
    return x;
  endfunction

  function automatic vec_t v(bit r, bit s, bit e, bit j, bit [L-1:0] ja, bit b, bit [L-1:0] bo, bit h,
                             bit [L-1:0] pc, bit run, bit hl, bit wr);
    vec_t x;
    x.s = st(r, s, e, j, ja, b, bo, h);
    x.pc = pc; x.run = run; x.hlt = hl; x.wr = wr;
    return x;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst;
    {b0.start, b0.enable, b0.jump, b0.jump_addr, b0.branch, b0.branch_offset, b0.halt} =
      {s.start, s.en, s.jmp, s.ja, s.br, s.bo, s.hlt};
    {b1.start, b1.enable, b1.jump, b1.jump_addr, b1.branch, b1.branch_offset, b1.halt} =
      {s.start, s.en, s.jmp, s.ja, s.br, s.bo, s.hlt};
    {b2.start, b2.enable, b2.jump, b2.jump_addr, b2.branch, b2.branch_offset, b2.halt} =
      {s.start, s.en, s.jmp, s.ja, s.br, s.bo, s.hlt};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    bit [L-1:0] pps;

    // rst, start, en, jmp, ja, br, bo, halt  ->  pc, running, halted, wrapped
    vq.push_back(v(1,0,0,0,'h000,0,'h000,0, 'h000,0,0,0));
    vq.push_back(v(1,0,0,0,'h000,0,'h000,0, 'h000,0,0,0));
    vq.push_back(v(0,1,1,0,'h000,0,'h000,0, 'h000,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,0, 'h001,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,0, 'h002,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,0, 'h003,1,0,0));
    vq.push_back(v(0,0,1,1,'h7FF,0,'h000,0, 'h7FF,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,0, 'h000,1,0,1));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,0, 'h001,1,0,0));
    vq.push_back(v(0,0,1,1,'h010,0,'h000,0, 'h010,1,0,0));
    vq.push_back(v(0,0,1,1,'h100,1,'h7FE,0, 'h100,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,1,'h7FE,0, 'h0FE,1,0,0));
    vq.push_back(v(0,0,1,1,'h005,0,'h000,0, 'h005,1,0,0));
    for (int i = 0; i < 3; i++)
      vq.push_back(v(0,0,0,1,'h200,0,'h000,0, 'h005,1,0,0));
    vq.push_back(v(0,0,0,1,'h200,0,'h000,1, 'h005,0,1,0));
    vq.push_back(v(0,1,1,0,'h000,0,'h000,0, 'h005,1,0,0));
    vq.push_back(v(0,0,1,1,'h020,0,'h000,0, 'h020,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,1, 'h020,0,1,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(v(0,0,1,1,'h300,1,'h010,0, 'h020,0,1,0));
    vq.push_back(v(0,1,1,0,'h000,0,'h000,0, 'h020,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,0, 'h021,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,1, 'h021,0,1,0));
    vq.push_back(v(0,1,1,0,'h000,0,'h000,1, 'h021,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,0, 'h022,1,0,0));
    vq.push_back(v(0,0,1,1,'h123,0,'h000,0, 'h123,1,0,0));
    vq.push_back(v(1,0,1,1,'h456,0,'h000,0, 'h000,0,0,0));
    vq.push_back(v(0,0,1,1,'h300,1,'h010,1, 'h000,0,0,0));
    vq.push_back(v(0,1,1,0,'h000,0,'h000,0, 'h000,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,0, 'h001,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,1,'h7FE,0, 'h7FF,1,0,0));
    vq.push_back(v(0,0,1,0,'h000,0,'h000,0, 'h000,1,0,1));

    drive(st(1,0,0,0,'h000,0,'h000,0));

    foreach (vq[i]) begin
      drive(vq[i].s);
      step();
      pps = vq[i].pc + L'(1);
      chk($sformatf("v%0d pc", i),      32'(b0.pc),           32'(vq[i].pc));
      chk($sformatf("v%0d running", i), 32'(b0.running),      32'(vq[i].run));
      chk($sformatf("v%0d halted", i),  32'(b0.halted),       32'(vq[i].hlt));
      chk($sformatf("v%0d wrapped", i), 32'(b0.wrapped),      32'(vq[i].wr));
      chk($sformatf("v%0d pc_plus", i), 32'(b0.pc_plus_step), 32'(pps));
    end

    // STEP=2 wrap and RESET_PC=0x040 reset value
    drive(st(1,0,0,0,'h000,0,'h000,0));
    step();
    chk("r40 pc",       32'(b2.pc),           32'h040);
    chk("r40 pc_plus",  32'(b2.pc_plus_step), 32'h041);
    chk("r40 running",  32'(b2.running),      32'h0);
    chk("s2 rst pc",    32'(b1.pc),           32'h000);
    chk("s2 rst plus",  32'(b1.pc_plus_step), 32'h002);
    drive(st(0,1,1,0,'h000,0,'h000,0));
    step();
    chk("r40 start run", 32'(b2.running), 32'h1);
    chk("r40 start pc",  32'(b2.pc),      32'h040);
    drive(st(0,0,1,1,'h7FF,0,'h000,0));
    step();
    chk("s2 jump pc",   32'(b1.pc),           32'h7FF);
    chk("s2 jump plus", 32'(b1.pc_plus_step), 32'h001);
    drive(st(0,0,1,0,'h000,0,'h000,0));
    step();
    chk("s2 wrap pc",   32'(b1.pc),      32'h001);
    chk("s2 wrap flag", 32'(b1.wrapped), 32'h1);
    chk("r40 wrap pc",  32'(b2.pc),      32'h000);
    step();
    chk("s2 next pc",   32'(b1.pc),      32'h003);
    chk("s2 next flag", 32'(b1.wrapped), 32'h0);
    drive(st(0,0,1,1,'h123,0,'h000,0));
    step();
    chk("r40 mid pc",   32'(b2.pc),      32'h123);
    drive(st(1,0,1,1,'h456,0,'h000,0));
    step();
    chk("r40 rst pc",      32'(b2.pc),           32'h040);
    chk("r40 rst plus",    32'(b2.pc_plus_step), 32'h041);
    chk("r40 rst running", 32'(b2.running),      32'h0);
    chk("r40 rst halted",  32'(b2.halted),       32'h0);
    chk("r40 rst wrapped", 32'(b2.wrapped),      32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
